// File: rtl/mux_nto1_stream_if.sv
// Bundle of the mux's select, input-stream and output-stream signals.
// Define MUX_CHID_EN to carry the granted channel index alongside the output word.
interface mux_nto1_stream_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned SEL_W = $clog2(N);

  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N*DATA_W-1:0]   in_data;
  logic [N-1:0]          in_valid;
  logic [N-1:0]          in_ready;
  logic [DATA_W-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;
`ifdef MUX_CHID_EN
  logic [SEL_W-1:0]      out_chid;
`endif

`ifdef MUX_CHID_EN
  modport master (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_chid
  );
  modport slave (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_chid
  );
`else
  modport master (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
  modport slave (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );
`endif
endinterface

// File: rtl/mux_nto1_stream.sv
// Registered N:1 stream mux with fixed-select and round-robin modes.
// Define MUX_CHID_EN to add the out_chid register (granted channel index).
module mux_nto1_stream #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  mux_nto1_stream_if.master     bus
);
  localparam int unsigned SEL_W = $clog2(N);

  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [SEL_W-1:0]  grant;
  logic              grant_valid;
  logic              can_load;
  logic              xfer;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
`ifdef MUX_CHID_EN
  logic [SEL_W-1:0]  out_chid_q, out_chid_d;
`endif

  assign can_load = !out_valid_q || bus.out_ready;

  // Round-robin scans farthest-to-nearest from ptr so the nearest valid channel wins.
  always_comb begin
    logic [SEL_W-1:0] idx;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = '0;
    if (!bus.mode) begin
      if (32'(bus.sel) < N && bus.in_valid[bus.sel]) begin
        grant       = bus.sel;
        grant_valid = 1'b1;
      end
    end else begin
      for (int unsigned k = N; k >= 1; k--) begin
        idx = SEL_W'((32'(ptr_q) + k) % N);
        if (bus.in_valid[idx]) begin
          grant       = idx;
          grant_valid = 1'b1;
        end
      end
    end
  end

  assign xfer = !rst && can_load && grant_valid;

  always_comb begin
    bus.in_ready = '0;
    if (xfer) bus.in_ready[grant] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef MUX_CHID_EN
    out_chid_d  = out_chid_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[32'(grant)*DATA_W +: DATA_W];
`ifdef MUX_CHID_EN
      out_chid_d  = grant;
`endif
      if (bus.mode) ptr_d = grant;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= SEL_W'(N - 1);
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef MUX_CHID_EN
      out_chid_q  <= '0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
`ifdef MUX_CHID_EN
      out_chid_q  <= out_chid_d;
`endif
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
`ifdef MUX_CHID_EN
  assign bus.out_chid  = out_chid_q;
`endif
endmodule
